fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter / instruction-fetch stage for the 9-bit core. Consumes branch_en
//  from the control decoder, plus the decoded halt. Produces PC, which addresses instrROM.
//  Branch targets are absolute and come from a loadable branch-target LUT indexed by an
//  instruction field. A Start/Done handshake and a run-cycle counter support benches.
// PARAMETERS
//  PC_W   10  width of PC (instruction memory depth 2**PC_W)
//  LUT_AW 6   branch-target LUT index width (2**LUT_AW entries of PC_W bits)
//  CNT_W  16  width of run-cycle counter
// PORTS
//  Clk         in  1       clock, all state updates on rising edge
//  Reset       in  1       asynchronous, active-high reset
//  Start       in  1       begin execution at Start_Addr (level sampled at edge)
//  Start_Addr  in  PC_W    first PC of program
//  branch_en   in  1       take branch this cycle (from control decoder)
//  Branch_idx  in  LUT_AW  LUT index of branch target (instruction field)
//  Halt        in  1       current instruction is halt
//  Lut_we      in  1       write enable for branch-target LUT
//  Lut_waddr   in  LUT_AW  LUT write index
//  Lut_wdata   in  PC_W    LUT write data (absolute target)
//  PC          out PC_W    current program counter
//  Running     out 1       1 while state==RUN
//  Done        out 1       1 while state==DONE (level, not pulse)
//  Cycle_count out CNT_W   clock edges spent in RUN since last start
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, PC=0, Running=0, Done=0, Cycle_count=0,
//   all LUT entries=0. Reset is honoured in any state, including mid-run.
//  States: IDLE, RUN, DONE. All outputs are decoded from registers, none from inputs.
//  IDLE: Start=1 -> PC<=Start_Addr, Cycle_count<=0, ->RUN. Otherwise hold.
//  RUN, per edge, priority Halt > branch_en > increment:
//   Halt=1      -> PC holds, ->DONE (branch_en ignored)
//   branch_en=1 -> PC<=LUT[Branch_idx]
//   else        -> PC<=PC+1 mod 2**PC_W (0x3FF -> 0x000 at default width)
//   Cycle_count increments on every RUN edge, including the halting edge.
//   It saturates at 2**CNT_W-1 and does not wrap.
//   Start is ignored in RUN.
//  DONE: PC and Cycle_count hold. branch_en and Halt are ignored.
//   Start=1 -> same action as in IDLE (Done falls, Running rises next cycle).
//  Latency: the PC change is visible one cycle after the edge sampling the control inputs.
//   No bubbles; one PC per cycle in RUN.
//  LUT: the read is combinational on Branch_idx. The write is synchronous when Lut_we=1,
//   in any state.
//   A write and a branch to the same index on the same edge: the branch uses the OLD
//   entry; the new value is visible from the next cycle.
//  branch_en/Halt outside RUN: no effect on PC or state.
// TESTING
//  1 Start_Addr=0x010, Start 1 cycle, no branch/halt, 3 edges in RUN
//    -> PC 0x010,0x011,0x012,0x013; Cycle_count=3.
//  2 Lut_we writes LUT[3]=0x1A0; later, at PC=0x020, branch_en=1, Branch_idx=3 -> next PC=0x1A0.
//    Same edge also writes LUT[3]=0x0F0 -> PC still 0x1A0; a repeat branch -> 0x0F0.
//  3 At PC=0x030, Halt=1 and branch_en=1 together
//    -> PC stays 0x030, Done=1, Running=0.
//    A further branch_en=1 -> PC unchanged.
//  4 Running at PC=0x005; Reset asserted mid-cycle
//    -> PC=0, Running=0, Done=0, Cycle_count=0 before the next edge.
//    LUT[3] reads 0 afterward.
//  5 Start_Addr=0x3FE, run 3 edges -> PC 0x3FF,0x000,0x001.
//    With CNT_W=4, run 20 edges -> Cycle_count=15 (saturated).
//  6 Start pulsed during RUN -> ignored, PC keeps incrementing.
//    Start in DONE -> PC=Start_Addr, Cycle_count=0, Done=0, Running=1.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch control for the 9-bit core, with a loadable
// branch-target LUT, Start/Done handshake and a saturating run-cycle counter.
module fetch_unit #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 6,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   Start_Addr,
    input  logic              branch_en,
    input  logic [LUT_AW-1:0] Branch_idx,
    input  logic              Halt,
    input  logic              Lut_we,
    input  logic [LUT_AW-1:0] Lut_waddr,
    input  logic [PC_W-1:0]   Lut_wdata,
    output logic [PC_W-1:0]   PC,
    output logic              Running,
    output logic              Done,
    output logic [CNT_W-1:0]  Cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [PC_W-1:0] lut [2**LUT_AW];
    logic [PC_W-1:0] target;
    // Combinational read sees the pre-edge entry, so a same-edge write is not forwarded.
    assign target = lut[Branch_idx];
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
        end else if (Lut_we) begin
            lut[Lut_waddr] <= Lut_wdata;
        end
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            PC          <= '0;
            Running     <= 1'b0;
            Done        <= 1'b0;
            Cycle_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state       <= RUN;
                        PC          <= Start_Addr;
                        Cycle_count <= '0;
                        Running     <= 1'b1;
                        Done        <= 1'b0;
                    end
                end
                RUN: begin
                    Cycle_count <= &Cycle_count ? Cycle_count : Cycle_count + 1'b1;
                    if (Halt) begin
                        state   <= DONE;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else begin
                        PC <= branch_en ? target : PC + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for reset, wrap and saturation.
module tb_fetch_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, br, halt, we;
    logic [9:0] sa, wdata;
    logic [5:0] idx, waddr;
    logic [9:0] pc, pc4;
    logic       run, done, run4, done4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .Clk(clk), .Reset(rst), .Start(start), .Start_Addr(sa), .branch_en(br),
        .Branch_idx(idx), .Halt(halt), .Lut_we(we), .Lut_waddr(waddr), .Lut_wdata(wdata),
        .PC(pc), .Running(run), .Done(done), .Cycle_count(cnt)
    );
    fetch_unit #(.CNT_W(4)) dut4 (
        .Clk(clk), .Reset(rst), .Start(start), .Start_Addr(sa), .branch_en(br),
        .Branch_idx(idx), .Halt(halt), .Lut_we(we), .Lut_waddr(waddr), .Lut_wdata(wdata),
        .PC(pc4), .Running(run4), .Done(done4), .Cycle_count(cnt4)
    );

    typedef struct {
        logic       start;
        logic [9:0] sa;
        logic       br;
        logic [5:0] idx;
        logic       halt;
        logic       we;
        logic [5:0] waddr;
        logic [9:0] wdata;
        logic [9:0] pc;
        logic       run;
        logic       done;
        int         cnt;
    } vec_t;

    function automatic vec_t v(logic s, logic [9:0] a, logic b, logic [5:0] i, logic h,
                               logic w, logic [5:0] wa, logic [9:0] wd,
                               logic [9:0] p, logic r, logic d, int c);
        vec_t t;
        t.start = s; t.sa = a; t.br = b; t.idx = i; t.halt = h;
        t.we = w; t.waddr = wa; t.wdata = wd;
        t.pc = p; t.run = r; t.done = d; t.cnt = c;
        return t;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; sa = '0; br = 0; idx = '0; halt = 0; we = 0; waddr = '0; wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = v(0, 10'h000, 1, 3, 1, 1, 3, 10'h1A0, 10'h000, 0, 0, 0);
        tbl[1]  = v(1, 10'h010, 0, 0, 0, 0, 0, 10'h000, 10'h010, 1, 0, 0);
        tbl[2]  = v(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h011, 1, 0, 1);
        tbl[3]  = v(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h012, 1, 0, 2);
        tbl[4]  = v(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h013, 1, 0, 3);
        tbl[5]  = v(0, 10'h000, 0, 0, 0, 1, 5, 10'h020, 10'h014, 1, 0, 4);
        tbl[6]  = v(0, 10'h000, 1, 5, 0, 0, 0, 10'h000, 10'h020, 1, 0, 5);
        tbl[7]  = v(0, 10'h000, 1, 3, 0, 1, 3, 10'h0F0, 10'h1A0, 1, 0, 6);
        tbl[8]  = v(0, 10'h000, 1, 3, 0, 0, 0, 10'h000, 10'h0F0, 1, 0, 7);
        tbl[9]  = v(1, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h0F1, 1, 0, 8);
        tbl[10] = v(0, 10'h000, 0, 0, 0, 1, 7, 10'h030, 10'h0F2, 1, 0, 9);
        tbl[11] = v(0, 10'h000, 1, 7, 0, 0, 0, 10'h000, 10'h030, 1, 0, 10);
        tbl[12] = v(0, 10'h000, 1, 3, 1, 0, 0, 10'h000, 10'h030, 0, 1, 11);
        tbl[13] = v(0, 10'h000, 1, 3, 0, 0, 0, 10'h000, 10'h030, 0, 1, 11);
        tbl[14] = v(0, 10'h000, 0, 0, 1, 0, 0, 10'h000, 10'h030, 0, 1, 11);
        tbl[15] = v(1, 10'h100, 0, 0, 0, 0, 0, 10'h000, 10'h100, 1, 0, 0);
        tbl[16] = v(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 10'h101, 1, 0, 1);

        rst = 1;
        idle_inputs();
        #1;
        check("reset_pc", pc, 0);
        check("reset_run", run, 0);
        check("reset_done", done, 0);
        check("reset_cnt", cnt, 0);
        step();
        rst = 0;
        step();

        for (int i = 0; i < 17; i++) begin
            start = tbl[i].start; sa = tbl[i].sa; br = tbl[i].br; idx = tbl[i].idx;
            halt = tbl[i].halt; we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            step();
            check($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
            check($sformatf("vec%0d_run", i), run, tbl[i].run);
            check($sformatf("vec%0d_done", i), done, tbl[i].done);
            check($sformatf("vec%0d_cnt", i), cnt, tbl[i].cnt);
            check($sformatf("vec%0d_cnt4", i), cnt4, tbl[i].cnt > 15 ? 15 : tbl[i].cnt);
        end
        idle_inputs();

        // Asynchronous reset in the middle of a run cycle.
        do_reset();
        start = 1; sa = 10'h003;
        step();
        idle_inputs();
        step();
        step();
        check("mid_pc_before", pc, 10'h005);
        #2 rst = 1;
        #1;
        check("async_pc", pc, 0);
        check("async_run", run, 0);
        check("async_done", done, 0);
        check("async_cnt", cnt, 0);
        @(negedge clk);
        rst = 0;
        start = 1; sa = 10'h040;
        step();
        start = 0; br = 1; idx = 3;
        step();
        check("lut_cleared", pc, 0);

        // PC wrap and counter saturation.
        do_reset();
        start = 1; sa = 10'h3FE;
        step();
        start = 0;
        check("wrap_start", pc, 10'h3FE);
        step();
        check("wrap_3ff", pc, 10'h3FF);
        step();
        check("wrap_000", pc, 10'h000);
        step();
        check("wrap_001", pc, 10'h001);
        for (int i = 0; i < 17; i++) step();
        check("sat_cnt4", cnt4, 15);
        check("cnt16_20", cnt, 20);
        check("sat_run4", run4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
